// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin switch allocator with wormhole locking.
// Each output port runs an IDLE/LOCKED FSM. In IDLE it grants one requesting input
// and then holds that input until it reports its tail flit has left the crossbar.
// Optional macro SA_WATCHDOG_EN: frees an output that stays LOCKED for TIMEOUT_CYC
// cycles and sets a sticky error flag.
module switch_allocator #(
    parameter int unsigned NUM_PORTS   = 5,
    parameter int unsigned PORT_W      = 3,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        i_switch_req,
    input  logic [NUM_PORTS*PORT_W-1:0] i_target_port,
    input  logic [NUM_PORTS-1:0]        i_packet_done,
    output logic [NUM_PORTS-1:0]        o_switch_ack,
    output logic [NUM_PORTS-1:0]        o_out_busy,
    output logic [NUM_PORTS*PORT_W-1:0] o_xbar_sel,
    output logic                        o_watchdog_err
);

    localparam logic [PORT_W-1:0] IDLE_SEL = PORT_W'(NUM_PORTS);

    // The idle select code must fit in PORT_W bits and the watchdog needs a nonzero limit.
    if (((1 << PORT_W) <= NUM_PORTS) || (TIMEOUT_CYC == 0)) begin : g_param_check
        $error("switch_allocator: invalid NUM_PORTS/PORT_W/TIMEOUT_CYC");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e               state_q [NUM_PORTS];
    state_e               state_d [NUM_PORTS];
    logic [PORT_W-1:0]    sel_q   [NUM_PORTS];
    logic [PORT_W-1:0]    sel_d   [NUM_PORTS];
    logic [PORT_W-1:0]    ptr_q   [NUM_PORTS];
    logic [PORT_W-1:0]    ptr_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0] ack_q;
    logic [NUM_PORTS-1:0] ack_d;

    logic [PORT_W-1:0]    tgt_c   [NUM_PORTS];
    logic [NUM_PORTS-1:0] owned_c;

`ifdef SA_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q [NUM_PORTS];
    logic [CNT_W-1:0] cnt_d [NUM_PORTS];
    logic             err_q;
    logic             err_d;
`endif

    // Split the packed target bus into one index per input.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            tgt_c[i] = i_target_port[i*PORT_W +: PORT_W];
        end
    end

    // Inputs that currently hold an output; they may not compete for another one.
    always_comb begin
        owned_c = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if ((state_q[j] == ST_LOCKED) && (sel_q[j] == PORT_W'(i))) begin
                    owned_c[i] = 1'b1;
                end
            end
        end
    end

    // Per-output next state: round-robin grant in IDLE, release on owner's packet done in LOCKED.
    always_comb begin
        logic [NUM_PORTS-1:0] cand;
        logic                 found;
        logic                 rel;
        int unsigned          idx;
        int unsigned          win;

        cand  = '0;
        found = 1'b0;
        rel   = 1'b0;
        idx   = 0;
        win   = 0;
        ack_d = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            state_d[j] = state_q[j];
            sel_d[j]   = sel_q[j];
            ptr_d[j]   = ptr_q[j];
        end
`ifdef SA_WATCHDOG_EN
        err_d = err_q;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            cnt_d[j] = cnt_q[j];
        end
`endif

        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            case (state_q[j])
                ST_IDLE: begin
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        cand[i] = i_switch_req[i] && (tgt_c[i] == PORT_W'(j)) && !owned_c[i];
                    end
                    found = 1'b0;
                    win   = 0;
                    for (int unsigned off = 0; off < NUM_PORTS; off++) begin
                        idx = 32'(ptr_q[j]) + off;
                        if (idx >= NUM_PORTS) begin
                            idx = idx - NUM_PORTS;
                        end
                        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                            if (!found && cand[i] && (idx == i)) begin
                                found = 1'b1;
                                win   = i;
                            end
                        end
                    end
                    if (found) begin
                        state_d[j] = ST_LOCKED;
                        sel_d[j]   = PORT_W'(win);
                        ptr_d[j]   = (win + 1 == NUM_PORTS) ? '0 : PORT_W'(win + 1);
                        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                            if (win == i) begin
                                ack_d[i] = 1'b1;
                            end
                        end
`ifdef SA_WATCHDOG_EN
                        cnt_d[j] = '0;
`endif
                    end
                end
                ST_LOCKED: begin
                    rel = 1'b0;
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        if ((sel_q[j] == PORT_W'(i)) && i_packet_done[i]) begin
                            rel = 1'b1;
                        end
                    end
`ifdef SA_WATCHDOG_EN
                    if (!rel) begin
                        if (cnt_q[j] == CNT_W'(TIMEOUT_CYC - 1)) begin
                            rel   = 1'b1;
                            err_d = 1'b1;
                        end else begin
                            cnt_d[j] = cnt_q[j] + CNT_W'(1);
                        end
                    end
`endif
                    if (rel) begin
                        state_d[j] = ST_IDLE;
                        sel_d[j]   = IDLE_SEL;
                    end
                end
                default: begin
                    state_d[j] = ST_IDLE;
                    sel_d[j]   = IDLE_SEL;
                end
            endcase
        end
    end

    // State registers; reset drops every lock and suppresses any pending ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= ST_IDLE;
                sel_q[j]   <= IDLE_SEL;
                ptr_q[j]   <= '0;
            end
            ack_q <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= state_d[j];
                sel_q[j]   <= sel_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
            ack_q <= ack_d;
        end
    end

`ifdef SA_WATCHDOG_EN
    // Lock-age counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                cnt_q[j] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NUM_PORTS; j++) begin
                cnt_q[j] <= cnt_d[j];
            end
            err_q <= err_d;
        end
    end

    assign o_watchdog_err = err_q;
`else
    assign o_watchdog_err = 1'b0;
`endif

    // Output mapping straight from the registers.
    always_comb begin
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            o_out_busy[j]                    = (state_q[j] == ST_LOCKED);
            o_xbar_sel[j*PORT_W +: PORT_W]   = sel_q[j];
        end
    end

    assign o_switch_ack = ack_q;

endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: scoreboard bench for switch_allocator (5 ports, 3-bit index).
// Stimulus pushes the expected {ack, busy, sel} snapshot for every grant it provokes;
// a negedge monitor pops and compares whenever an ack appears.
module tb_switch_allocator;

    localparam int unsigned N  = 5;
    localparam int unsigned PW = 3;
`ifdef SA_WATCHDOG_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 256;
`endif

    typedef struct packed {
        logic [N-1:0]    ack;
        logic [N-1:0]    busy;
        logic [N*PW-1:0] sel;
    } exp_t;

    localparam logic [N*PW-1:0] ALL_IDLE = {5{3'd5}};

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req   = '0;
    logic [N*PW-1:0] tgt   = {5{3'd7}};
    logic [N-1:0]    done  = '0;
    logic [N-1:0]    ack;
    logic [N-1:0]    busy;
    logic [N*PW-1:0] sel;
    logic            wd_err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   order [6] = '{0, 1, 3, 0, 1, 3};

    switch_allocator #(
        .NUM_PORTS  (N),
        .PORT_W     (PW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_switch_req  (req),
        .i_target_port (tgt),
        .i_packet_done (done),
        .o_switch_ack  (ack),
        .o_out_busy    (busy),
        .o_xbar_sel    (sel),
        .o_watchdog_err(wd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [N*PW-1:0] sv5(input int s0, input int s1, input int s2,
                                            input int s3, input int s4);
        return {3'(s4), 3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int t);
        req[i] = 1'b1;
        tgt[i*PW +: PW] = 3'(t);
    endtask

    task automatic clr_req(input int i);
        req[i] = 1'b0;
        tgt[i*PW +: PW] = 3'd7;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N*PW-1:0] s);
        exp_t e;
        e.ack  = a;
        e.busy = b;
        e.sel  = s;
        exp_q.push_back(e);
    endtask

    task automatic check_state(input string name, input logic [N-1:0] eb,
                               input logic [N*PW-1:0] es, input logic ee);
        @(negedge clk);
        n_checks++;
        if (busy !== eb || sel !== es || wd_err !== ee) begin
            n_fail++;
            $display("FAIL %s: got busy=%b sel=%b err=%b, required busy=%b sel=%b err=%b",
                     name, busy, sel, wd_err, eb, es, ee);
        end
    endtask

    // Monitor: every ack pulse must match the next expected grant snapshot.
    always @(negedge clk) begin
        if (ack !== '0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: got ack=%b busy=%b sel=%b, required no ack",
                         ack, busy, sel);
            end else begin
                mon_e = exp_q.pop_front();
                if (ack !== mon_e.ack || busy !== mon_e.busy || sel !== mon_e.sel) begin
                    n_fail++;
                    $display("FAIL ack_event: got ack=%b busy=%b sel=%b, required ack=%b busy=%b sel=%b",
                             ack, busy, sel, mon_e.ack, mon_e.busy, mon_e.sel);
                end
            end
        end
    end

    initial begin
        // Reset, then idle for 10 cycles.
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_state("reset_idle", 5'b00000, ALL_IDLE, 1'b0);
        end

        // Single request: input 2 -> port 4.
        set_req(2, 4);
        push(5'b00100, 5'b10000, sv5(5, 5, 5, 5, 2));
        tick();
        clr_req(2);
        tick();
        check_state("single_locked", 5'b10000, sv5(5, 5, 5, 5, 2), 1'b0);
        done[2] = 1'b1;
        tick();
        done[2] = 1'b0;
        check_state("single_release", 5'b00000, ALL_IDLE, 1'b0);

        // Contention on port 2 from inputs 0, 1, 3: grant order 0,1,3,0,1,3.
        set_req(0, 2);
        set_req(1, 2);
        set_req(3, 2);
        for (int k = 0; k < 6; k++) begin
            push(5'(1 << order[k]), 5'b00100, sv5(5, 5, order[k], 5, 5));
            tick();
            if (k == 5) begin
                clr_req(0);
                clr_req(1);
                clr_req(3);
            end
            tick();
            tick();
            done[order[k]] = 1'b1;
            tick();
            done = '0;
            check_state("rr_bubble", 5'b00000, ALL_IDLE, 1'b0);
        end

        // Lock hold: owner 1 on port 0 drops its request; input 4 waits for the done.
        set_req(1, 0);
        push(5'b00010, 5'b00001, sv5(1, 5, 5, 5, 5));
        tick();
        clr_req(1);
        set_req(4, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_state("lock_hold", 5'b00001, sv5(1, 5, 5, 5, 5), 1'b0);
        end
        done[1] = 1'b1;
        tick();
        done[1] = 1'b0;
        check_state("lock_release", 5'b00000, ALL_IDLE, 1'b0);
        push(5'b10000, 5'b00001, sv5(4, 5, 5, 5, 5));
        tick();
        clr_req(4);
        done[4] = 1'b1;
        tick();
        done[4] = 1'b0;
        check_state("lock_release2", 5'b00000, ALL_IDLE, 1'b0);

        // Parallel grants, an out-of-range target and stray packet-done pulses.
        set_req(0, 1);
        set_req(3, 2);
        set_req(4, 7);
        push(5'b01001, 5'b00110, sv5(5, 0, 3, 5, 5));
        tick();
        clr_req(0);
        clr_req(3);
        repeat (3) tick();
        check_state("parallel_locked", 5'b00110, sv5(5, 0, 3, 5, 5), 1'b0);
        done[4] = 1'b1;
        done[1] = 1'b1;
        tick();
        done = '0;
        check_state("stray_done", 5'b00110, sv5(5, 0, 3, 5, 5), 1'b0);
        // Release of port 1 and a new grant on port 3 at the same edge.
        done[0] = 1'b1;
        set_req(2, 3);
        push(5'b00100, 5'b01100, sv5(5, 5, 3, 2, 5));
        tick();
        done[0] = 1'b0;
        clr_req(2);
        check_state("simultaneous", 5'b01100, sv5(5, 5, 3, 2, 5), 1'b0);
        done[3] = 1'b1;
        done[2] = 1'b1;
        tick();
        done = '0;
        check_state("parallel_release", 5'b00000, ALL_IDLE, 1'b0);
        repeat (3) tick();
        clr_req(4);
        check_state("none_port_idle", 5'b00000, ALL_IDLE, 1'b0);

        // Reset mid-packet drops the lock, suppresses a same-cycle grant, clears pointers.
        set_req(1, 4);
        push(5'b00010, 5'b10000, sv5(5, 5, 5, 5, 1));
        tick();
        clr_req(1);
        tick();
        check_state("pre_reset_lock", 5'b10000, sv5(5, 5, 5, 5, 1), 1'b0);
        set_req(0, 0);
        reset = 1'b1;
        tick();
        check_state("mid_reset", 5'b00000, ALL_IDLE, 1'b0);
        reset = 1'b0;
        clr_req(0);
        set_req(1, 4);
        set_req(3, 4);
        push(5'b00010, 5'b10000, sv5(5, 5, 5, 5, 1));
        tick();
        clr_req(1);
        clr_req(3);
        tick();
        done[1] = 1'b1;
        tick();
        done[1] = 1'b0;
        check_state("post_reset_release", 5'b00000, ALL_IDLE, 1'b0);

        // Input 0 locks port 3 and never signals done.
        set_req(0, 3);
        push(5'b00001, 5'b01000, sv5(5, 5, 5, 0, 5));
        tick();
        clr_req(0);
`ifdef SA_WATCHDOG_EN
        repeat (15) tick();
        check_state("wd_last_locked", 5'b01000, sv5(5, 5, 5, 0, 5), 1'b0);
        tick();
        check_state("wd_fired", 5'b00000, ALL_IDLE, 1'b1);
        repeat (5) tick();
        check_state("wd_sticky", 5'b00000, ALL_IDLE, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_state("wd_reset", 5'b00000, ALL_IDLE, 1'b0);
`else
        for (int k = 0; k < 10; k++) begin
            repeat (100) tick();
            check_state("lock_persist", 5'b01000, sv5(5, 5, 5, 0, 5), 1'b0);
        end
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        check_state("persist_release", 5'b00000, ALL_IDLE, 1'b0);
`endif

        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_acks: got %0d grants still pending, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Per-output switch allocator for the router crossbar.
- Input units raise a switch request carrying a target output port. The allocator arbitrates each output port independently with a round-robin policy.
- It returns a one-cycle switch ack to the winning input and drives the crossbar select for that output.
- The output stays locked to the winner until that input reports packet done (tail sent). This keeps wormhole packets contiguous.

Parameters:
- NUM_PORTS, 5, number of router ports, input and output (N, E, S, W, Local).
- PORT_W, 3, width of a port index; must satisfy 2^PORT_W > NUM_PORTS.
- TIMEOUT_CYC, 256, watchdog limit in cycles; used only with SA_WATCHDOG_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- i_switch_req  in  NUM_PORTS  per-input request, level, held until acked.
- i_target_port  in  NUM_PORTS*PORT_W  per-input requested output; slice i is input i. Value NUM_PORTS or above means NONE_PORT.
- i_packet_done  in  NUM_PORTS  per-input one-cycle pulse when the tail flit has left the crossbar.
- o_switch_ack  out  NUM_PORTS  per-input one-cycle grant pulse.
- o_out_busy  out  NUM_PORTS  per-output: locked to an input.
- o_xbar_sel  out  NUM_PORTS*PORT_W  per-output selected input index; slice j is output j. Value is NUM_PORTS when the output is idle.
- o_watchdog_err  out  1  sticky watchdog flag; constant 0 without the macro.

Behaviour:
- Reset (sync, active-high, at clk edge):
  - o_switch_ack=0, o_out_busy=0.
  - Every o_xbar_sel slice = NUM_PORTS.
  - Round-robin pointers = 0, o_watchdog_err=0.
  - Reset asserted mid-packet drops every lock immediately; no ack is issued in that cycle.
- One FSM per output j, with states IDLE and LOCKED.
- IDLE:
  - Candidates are inputs i with i_switch_req[i]=1, target[i]==j, and input i not currently owner of any output.
  - If any candidate exists: winner = first candidate at or after ptr[j], scanning modulo NUM_PORTS.
  - Registered at the next edge: state=LOCKED, owner=winner, o_xbar_sel[j]=winner, o_out_busy[j]=1, o_switch_ack[winner]=1 for exactly one cycle, ptr[j]=(winner+1) mod NUM_PORTS.
  - Latency: request visible at edge k, ack high during cycle k+1.
- LOCKED:
  - Holds owner regardless of i_switch_req, so deassertion does not release.
  - On i_packet_done[owner]=1 the next edge goes to IDLE: o_out_busy[j]=0, o_xbar_sel[j]=NUM_PORTS.
  - Re-arbitration happens in the following IDLE cycle, giving a fixed one-cycle bubble between packets on the same output.
- Input conditions:
  - i_packet_done from a non-owner input is ignored.
  - NONE_PORT or out-of-range targets are never granted and never acked.
- Acks:
  - An input can own at most one output. Each input targets one port, so at most one o_switch_ack bit per input is set per cycle.
  - Several outputs may ack different inputs in the same cycle.
- Simultaneous events: packet done on output j and a new request to output k≠j in the same cycle are handled independently, and both take effect at the same edge.
- Round-robin fairness: with all NUM_PORTS inputs continuously requesting output j, each input is granted once every NUM_PORTS grants.

Optional Feature:
- Macro: SA_WATCHDOG_EN.
- Defined:
  - Each output has a counter of $clog2(TIMEOUT_CYC+1) bits, cleared on entering LOCKED and incremented each LOCKED cycle.
  - When it reaches TIMEOUT_CYC without packet done, the output is forced to IDLE at the next edge and o_watchdog_err is set.
  - The flag stays set until reset.
- Not defined: no counters are built, o_watchdog_err is tied to 0, and a lock persists indefinitely.

Test Plan:
- Reset then idle: all o_xbar_sel slices = 5, o_out_busy=5'b00000, o_switch_ack=0 for 10 cycles.
- Single request: input 2 targets port 4 at cycle 0 -> o_switch_ack=5'b00100 in cycle 1 only, o_xbar_sel[4]=2, o_out_busy[4]=1. Pulse i_packet_done[2] -> o_out_busy[4]=0 and sel=5 one cycle later.
- Contention and round-robin: inputs 0, 1, 3 all target port 2 continuously, each pulsing packet done 3 cycles after its ack -> grant order 0,1,3,0,1,3 with a one-cycle bubble between each release and the next ack.
- Lock hold: owner input 1 on port 0 drops i_switch_req. Input 4 requests port 0 -> no ack to 4 until i_packet_done[1]. Then ack to 4 two cycles after the done pulse.
- Parallel and invalid: input 0 targets 1 and input 3 targets 2 in the same cycle -> o_switch_ack=5'b01001 in one cycle. Input 4 targeting 7 -> never acked. i_packet_done[4] while it owns nothing -> no state change.
- Watchdog (SA_WATCHDOG_EN, TIMEOUT_CYC=16): input 0 locks port 3 and never signals done -> port 3 freed and o_watchdog_err=1 after 16 LOCKED cycles. The flag clears only on reset. Without the macro the lock persists past 1000 cycles and o_watchdog_err stays 0.
